// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo counter family.
// Imported by the counter RTL and by anything that models it.
package counter_pkg;

    localparam bit CNT_WRAP = 1'b0;
    localparam bit CNT_SAT  = 1'b1;

    function automatic logic [31:0] clamp_max(
        input logic [31:0] value,
        input logic [31:0] max
    );
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Up/down modulo counter with load, wrap/saturate mode,
// tc pulse and sticky overflow/underflow flags.
module mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = 32'((64'd1 << WIDTH) - 64'd1),
    parameter bit          SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_flags,
    output logic [WIDTH-1:0] counter_out,
    output logic             tc_out,
    output logic             overflow_out,
    output logic             underflow_out
);

    // One extra bit so the boundary compare never aliases.
    localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH:0]   cnt_x;
    logic             up_evt, dn_evt;

    assign cnt_x = {1'b0, cnt_q};

    always_comb begin
        cnt_d  = cnt_q;
        tc_d   = 1'b0;
        up_evt = 1'b0;
        dn_evt = 1'b0;
        if (load) begin
            cnt_d = WIDTH'(clamp_max(32'(load_value), MAX_VAL));
        end else if (enable) begin
            if (up_down) begin
                if (cnt_x == MAX_X) begin
                    up_evt = 1'b1;
                    tc_d   = 1'b1;
                    cnt_d  = (SATURATE == CNT_SAT) ? cnt_q : '0;
                end else begin
                    cnt_d = WIDTH'(cnt_x + ONE_X);
                end
            end else begin
                if (cnt_x == '0) begin
                    dn_evt = 1'b1;
                    tc_d   = 1'b1;
                    cnt_d  = (SATURATE == CNT_SAT) ? cnt_q : WIDTH'(MAX_X);
                end else begin
                    cnt_d = WIDTH'(cnt_x - ONE_X);
                end
            end
        end
    end

    // An event in the same cycle as a clear keeps its own flag.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (clear_flags) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (up_evt) ovf_d = 1'b1;
        if (dn_evt) unf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign counter_out   = cnt_q;
    assign tc_out        = tc_q;
    assign overflow_out  = ovf_q;
    assign underflow_out = unf_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: wrap, saturate and full-width
// instances driven from shared stimulus.
module tb_mod_counter;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       up_down = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = '0;
    logic       clear_flags = 1'b0;

    logic [3:0] w_cnt, s_cnt;
    logic [7:0] f_cnt;
    logic       w_tc, w_ov, w_un;
    logic       s_tc, s_ov, s_un;
    logic       f_tc, f_ov, f_un;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(CNT_WRAP)) u_w (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value[3:0]),
        .clear_flags(clear_flags), .counter_out(w_cnt), .tc_out(w_tc),
        .overflow_out(w_ov), .underflow_out(w_un)
    );

    mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(CNT_SAT)) u_s (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value[3:0]),
        .clear_flags(clear_flags), .counter_out(s_cnt), .tc_out(s_tc),
        .overflow_out(s_ov), .underflow_out(s_un)
    );

    mod_counter #(.WIDTH(8)) u_f (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value),
        .clear_flags(clear_flags), .counter_out(f_cnt), .tc_out(f_tc),
        .overflow_out(f_ov), .underflow_out(f_un)
    );

    typedef struct {
        logic       en;
        logic       ud;
        logic       ld;
        logic [7:0] lv;
        logic       clr;
        logic [3:0] cnt;
        logic       tc;
        logic       ov;
        logic       un;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic ud, input logic ld,
                         input logic [7:0] lv, input logic clr);
        enable      = en;
        up_down     = ud;
        load        = ld;
        load_value  = lv;
        clear_flags = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int tcs;
        // Table for the wrap instance, starting from 0 with clear flags.
        for (int i = 0; i < 9; i++)
            tbl.push_back('{1, 1, 0, 0, 0, 4'(i + 1), 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 1, 1, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 1, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 2, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 2, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 14, 0, 9, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 9, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 1, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 9, 1, 1, 1});
        tbl.push_back('{1, 1, 0, 0, 1, 0, 1, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 9, 1, 0, 1});
        tbl.push_back('{0, 0, 1, 3, 0, 3, 0, 0, 1});

        #2;
        chk("rst_cnt", w_cnt, 0);
        chk("rst_tc", w_tc, 0);
        chk("rst_ov", w_ov, 0);
        chk("rst_un", w_un, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;

        // Build up state, then assert reset mid-count at 5.
        drive(0, 0, 1, 9, 0); tick();
        drive(1, 1, 0, 0, 0); tick();
        chk("pre_wrap_ov", w_ov, 1);
        drive(0, 0, 1, 5, 0); tick();
        chk("pre_cnt5", w_cnt, 5);
        drive(1, 1, 0, 0, 0);
        #3;
        reset = 1'b0;
        #1;
        chk("async_cnt", w_cnt, 0);
        chk("async_tc", w_tc, 0);
        chk("async_ov", w_ov, 0);
        chk("async_un", w_un, 0);
        tick();
        chk("rst_hold_cnt", w_cnt, 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_cnt", w_cnt, 0);
            chk("idle_flags", {w_ov, w_un, w_tc}, 0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].ud, tbl[i].ld, tbl[i].lv, tbl[i].clr);
            tick();
            chk($sformatf("tbl%0d_cnt", i), w_cnt, tbl[i].cnt);
            chk($sformatf("tbl%0d_tc", i), w_tc, tbl[i].tc);
            chk($sformatf("tbl%0d_ov", i), w_ov, tbl[i].ov);
            chk($sformatf("tbl%0d_un", i), w_un, tbl[i].un);
        end

        // Saturate down from 2.
        drive(0, 0, 1, 2, 1); tick();
        chk("sat_ld_cnt", s_cnt, 2);
        chk("sat_ld_flags", {s_ov, s_un}, 0);
        drive(1, 0, 0, 0, 0);
        tick();
        chk("sat_d1_cnt", s_cnt, 1);
        chk("sat_d1_tc", s_tc, 0);
        tick();
        chk("sat_d2_cnt", s_cnt, 0);
        chk("sat_d2_tc", s_tc, 0);
        chk("sat_d2_un", s_un, 0);
        tick();
        chk("sat_d3_cnt", s_cnt, 0);
        chk("sat_d3_tc", s_tc, 1);
        chk("sat_d3_un", s_un, 1);
        tick();
        chk("sat_d4_cnt", s_cnt, 0);
        chk("sat_d4_tc", s_tc, 1);
        chk("sat_d4_ov", s_ov, 0);
        drive(0, 0, 0, 0, 0); tick();
        chk("sat_idle_tc", s_tc, 0);
        chk("sat_idle_un", s_un, 1);

        // Saturate up at MAX_VAL holds.
        drive(0, 0, 1, 9, 0); tick();
        drive(1, 1, 0, 0, 0); tick();
        chk("sat_up_cnt", s_cnt, 9);
        chk("sat_up_ov", s_ov, 1);

        // Full width up from 254.
        drive(0, 0, 1, 254, 1); tick();
        chk("full_ld", f_cnt, 254);
        drive(1, 1, 0, 0, 0);
        tcs = 0;
        tick();
        chk("full_c1", f_cnt, 255);
        tcs += int'(f_tc);
        tick();
        chk("full_c2", f_cnt, 0);
        tcs += int'(f_tc);
        tick();
        chk("full_c3", f_cnt, 1);
        tcs += int'(f_tc);
        chk("full_ov", f_ov, 1);
        chk("full_tc_count", tcs, 1);
        drive(0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
